ifu_fetch: RTL

Instruction fetch unit; the producer side of the 32-bit instruction word consumed by the decoder.
- Holds the architectural PC and issues one instruction-memory read per instruction.
- Presents the fetched word plus its PC to the decoder with a valid/ready handshake.
- Waits for the resolved next PC from the execute/writeback path before fetching again.
- Targets the multicycle NPC: at most one fetch in flight.

---
 rtl/ifu_fetch.sv | 105 ++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one read in flight, instruction handed to the
// decoder by valid/ready, then waits for the resolved next PC.
module ifu_fetch #(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             req_valid,
   input  logic             req_ready,
   output logic [WIDTH-1:0] req_addr,
   input  logic             resp_valid,
   input  logic [31:0]      resp_data,
   input  logic             resp_err,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [31:0]      inst,
   output logic [WIDTH-1:0] pc,
   output logic             fetch_fault,
   input  logic             next_pc_valid,
   input  logic [WIDTH-1:0] next_pc,
   output logic [63:0]      fetch_cnt
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] REQ     = 3'd1;
   localparam logic [2:0] RESP    = 3'd2;
   localparam logic [2:0] OUT     = 3'd3;
   localparam logic [2:0] WAIT_PC = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [31:0]      inst_q, inst_d;
   logic             fault_q, fault_d;
   logic [63:0]      cnt_q, cnt_d;
   logic             misalign;

   assign misalign = |pc_q[1:0];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      fault_d = fault_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (misalign) begin
               inst_d  = 32'h0;
               fault_d = 1'b1;
               state_d = OUT;
            end else if (req_ready) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (resp_valid) begin
               inst_d  = resp_data;
               fault_d = resp_err;
               state_d = OUT;
            end
         end
         OUT: begin
            if (inst_ready) begin
               cnt_d   = cnt_q + 64'd1;
               state_d = WAIT_PC;
            end
         end
         WAIT_PC: begin
            if (next_pc_valid) begin
               pc_d    = next_pc;
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= 32'h0;
         fault_q <= 1'b0;
         cnt_q   <= 64'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake outputs are gated by rst_n so they drop the moment reset asserts
   assign req_valid   = rst_n && (state_q == REQ) && !misalign;
   assign req_addr    = pc_q;
   assign inst_valid  = rst_n && (state_q == OUT);
   assign inst        = inst_q;
   assign pc          = pc_q;
   assign fetch_fault = fault_q;
   assign fetch_cnt   = cnt_q;

endmodule
